io_bus_bridge: RTL

Sits directly downstream of the `cpu` memory port and owns everything past it.
- Splits the CPU byte bus into a RAM path (addresses below 0x30000) and a memory-mapped I/O path (`mem_a[17:16]==2'b11`).
- I/O path contains a transmit FIFO with backpressure (`io_buffer_full`), a receive-byte pop interface, a free-running cycle counter readable at 0x30004, and program-end detection.
- Enforces the CPU contract: read data valid exactly one cycle after the address; writes take effect in one cycle.

---
 rtl/io_bus_bridge.sv | 135 +++++++++++++
 1 files changed

// File: rtl/io_bus_bridge.sv
// rtl/io_bus_bridge.sv - CPU byte-bus splitter: RAM path plus memory-mapped TX FIFO, RX pop, cycle counter and program-end.
module io_bus_bridge #(
  parameter int TX_DEPTH_LOG2 = 3,
  parameter int FULL_MARGIN   = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [16:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_we,
  input  logic [7:0]  ram_din,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_end,
  output logic        tx_overflow
);

  localparam int DEPTH = 1 << TX_DEPTH_LOG2;
  localparam logic [TX_DEPTH_LOG2:0] DEPTH_C  = (TX_DEPTH_LOG2+1)'(DEPTH);
  localparam logic [TX_DEPTH_LOG2:0] MARGIN_C = (TX_DEPTH_LOG2+1)'(FULL_MARGIN);
  localparam logic [17:0] ADDR_TX  = 18'h30000;
  localparam logic [17:0] ADDR_CNT = 18'h30004;

  logic [17:0] a18;
  logic        is_io, io_rd, io_wr;
  logic        rd_tx, rd_cnt, wr_tx, wr_end;
  logic [7:0]  io_byte, io_byte_q;
  logic        sel_io, sel_ram;
  logic [31:0] counter, snap;

  logic [7:0]               mem [DEPTH];
  logic [TX_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [TX_DEPTH_LOG2:0]   count, count_nxt, free_nxt;
  logic                     push, push_ok, pop;
  logic [7:0]               push_data;

  assign a18    = cpu_a[17:0];
  assign is_io  = (a18[17:16] == 2'b11);
  assign io_rd  = is_io & ~cpu_wr;
  assign io_wr  = is_io & cpu_wr;

  assign ram_a    = cpu_a[16:0];
  assign ram_dout = cpu_dout;
  assign ram_we   = cpu_wr & ~is_io;

  assign rd_tx  = io_rd && (a18 == ADDR_TX);
  assign rd_cnt = io_rd && (a18[17:2] == ADDR_CNT[17:2]);
  assign wr_tx  = io_wr && (a18 == ADDR_TX) && (cpu_dout != 8'h00);
  assign wr_end = io_wr && (a18 == ADDR_CNT);
  assign rx_pop = rd_tx & rx_valid;

  // Byte 0 reads the live counter; the same read loads the snapshot for bytes 1-3.
  always_comb begin
    io_byte = 8'h00;
    if (rd_tx && rx_valid) begin
      io_byte = rx_data;
    end else if (rd_cnt) begin
      case (a18[1:0])
        2'd0:    io_byte = counter[7:0];
        2'd1:    io_byte = snap[15:8];
        2'd2:    io_byte = snap[23:16];
        default: io_byte = snap[31:24];
      endcase
    end
  end

  assign cpu_din = sel_io ? io_byte_q : (sel_ram ? ram_din : 8'h00);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel_io      <= 1'b0;
      sel_ram     <= 1'b0;
      io_byte_q   <= 8'h00;
      counter     <= 32'd0;
      snap        <= 32'd0;
      program_end <= 1'b0;
    end else begin
      sel_io    <= io_rd;
      sel_ram   <= ~is_io & ~cpu_wr;
      io_byte_q <= io_byte;
      counter   <= counter + 32'd1;
      if (rd_cnt && (a18[1:0] == 2'd0)) snap <= counter;
      if (wr_end) program_end <= 1'b1;
    end
  end

  assign push      = wr_tx | wr_end;
  assign push_data = wr_end ? 8'h00 : cpu_dout;
  assign push_ok   = push && (count != DEPTH_C);
  assign pop       = tx_valid & tx_ready;
  assign tx_valid  = (count != '0);
  assign tx_data   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + (TX_DEPTH_LOG2+1)'(1);
      2'b01:   count_nxt = count - (TX_DEPTH_LOG2+1)'(1);
      default: count_nxt = count;
    endcase
  end

  assign free_nxt = DEPTH_C - count_nxt;

  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Full is flagged early so writes already in flight from the CPU still fit.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      io_buffer_full <= 1'b0;
      tx_overflow    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + TX_DEPTH_LOG2'(1);
      if (pop)     rd_ptr <= rd_ptr + TX_DEPTH_LOG2'(1);
      count          <= count_nxt;
      io_buffer_full <= (free_nxt <= MARGIN_C);
      if (push && !push_ok) tx_overflow <= 1'b1;
    end
  end

endmodule
